// File: rtl/fruit_template_matcher_if.sv
// Purpose: bundles the start/config, feature stream, ROM read port and result
//          signals of fruit_template_matcher into one port.
// Ports:   master = feature/ROM source side, slave = matcher side.
interface fruit_template_matcher_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11,
  parameter int SAD_WIDTH  = DATA_WIDTH + LEN_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic [SAD_WIDTH-1:0]  threshold;
  logic                  feat_valid;
  logic [DATA_WIDTH-1:0] feat_data;
  logic                  feat_ready;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  busy;
  logic                  done;
  logic [SAD_WIDTH-1:0]  sad;
  logic                  match;

  modport master (
    output start, base_addr, length, threshold, feat_valid, feat_data, rom_data,
    input  feat_ready, rom_addr, busy, done, sad, match
  );

  modport slave (
    input  start, base_addr, length, threshold, feat_valid, feat_data, rom_data,
    output feat_ready, rom_addr, busy, done, sad, match
  );
endinterface

// File: rtl/fruit_template_matcher.sv
// Purpose: streams a template ROM window against feature bytes, accumulates the
//          sum of absolute differences and flags sad < threshold.
// Latency/backpressure: start-to-done N+2 cycles with continuous feat_valid;
//          feat_valid gaps stall the window one cycle each, ROM address holds.
// Ports: i_clk, i_rst_n (sync, active-low), io_bus (slave modport: start/config,
//          feat_valid/feat_ready/feat_data, rom_addr/rom_data, busy/done/sad/match).
module fruit_template_matcher #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11,
  parameter int SAD_WIDTH  = DATA_WIDTH + LEN_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  fruit_template_matcher_if.slave   io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_a_q;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [SAD_WIDTH-1:0]  r_thr;
  logic [SAD_WIDTH-1:0]  r_acc;
  logic [SAD_WIDTH-1:0]  r_sad;
  logic                  r_match;
  logic                  r_done;

  logic                  w_hs;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [SAD_WIDTH-1:0]  w_acc_nxt;

  assign w_hs       = (r_state == S_RUN) && io_bus.feat_valid;
  assign w_last     = (r_cnt == r_len - LEN_WIDTH'(1));
  assign w_addr_inc = r_a_q + ADDR_WIDTH'(1);
  assign w_diff     = (io_bus.feat_data >= io_bus.rom_data) ?
                      (io_bus.feat_data - io_bus.rom_data) :
                      (io_bus.rom_data - io_bus.feat_data);
  assign w_acc_nxt  = r_acc + SAD_WIDTH'(w_diff);

  // Look ahead one address on a handshake so the ROM's one-cycle latency
  // delivers T[a_q] exactly when the next feature byte can be accepted.
  assign io_bus.rom_addr   = w_hs ? w_addr_inc : r_a_q;
  assign io_bus.feat_ready = (r_state == S_RUN);
  assign io_bus.busy       = (r_state == S_PRIME) || (r_state == S_RUN);
  assign io_bus.done       = r_done;
  assign io_bus.sad        = r_sad;
  assign io_bus.match      = r_match;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a_q   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_thr   <= '0;
      r_acc   <= '0;
      r_sad   <= '0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_len <= io_bus.length;
            r_thr <= io_bus.threshold;
            r_a_q <= io_bus.base_addr;
            r_cnt <= '0;
            r_acc <= '0;
            if (io_bus.length != '0) begin
              r_state <= S_PRIME;
            end else begin
              // Empty window: result is known immediately, no ROM access.
              r_state <= S_DONE;
              r_sad   <= '0;
              r_match <= (io_bus.threshold != '0);
              r_done  <= 1'b1;
            end
          end
        end
        S_PRIME: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_hs) begin
            r_acc <= w_acc_nxt;
            r_a_q <= w_addr_inc;
            r_cnt <= r_cnt + LEN_WIDTH'(1);
            if (w_last) begin
              // Result registered on entry to DONE so it is valid with done.
              r_state <= S_DONE;
              r_sad   <= w_acc_nxt;
              r_match <= (w_acc_nxt < r_thr);
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
